act_lane_scheduler: RTL and testbench
=====================================

# act_lane_scheduler

Shares one 2-lane pipelined Q5.11 tanh unit (tanh7slices: clk, rst_n, x0/x1_in, valid_in → y0/y1_out, valid_out, fixed latency, no stall) between a tanh requester (A) and a sigmoid requester (S). Round-robin arbitration grants both lanes to one requester per cycle. The block tags every issued pair through the unit's latency and derives sigmoid as sigmoid(x) = (1 + tanh(x/2)) / 2. Results are buffered in per-requester output FIFOs, with credit-based flow control because the tanh unit cannot stall.

## Interface
- LAT, 3: cycles from tanh valid_in to valid_out; must match the instantiated unit, ≥1.
- DEPTH, 4: output FIFO depth per requester, in pair entries, power of two, ≥2.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid, a_ready  in/out  1  tanh request handshake.
- a_x0, a_x1  in  16  Q5.11 operands. a_pair  in  1: 1 = both lanes valid, 0 = lane 0 only.
- s_valid, s_ready, s_x0, s_x1, s_pair: same as A, sigmoid requester.
- ra_valid, ra_ready  out/in  1  tanh response handshake. ra_y0, ra_y1  out  16  results. ra_pair  out  1.
- rs_valid, rs_ready, rs_y0, rs_y1, rs_pair: same as A, sigmoid response.
- t_valid  out  1; t_x0, t_x1  out  16: drive tanh unit inputs.
- t_valid_out  in  1; t_y0, t_y1  in  16: tanh unit outputs.
- err  out  1  sticky: t_valid_out disagreed with internal tag pipe.

## Operation
- Credit counter per requester, cred_a and cred_s, range 0..DEPTH. +1 on request handshake, −1 on response handshake; unchanged when both happen in one cycle. Requester eligible iff cred < DEPTH.
- Grant: a_ready = elig_a && (!s_valid || !elig_s || rr==A); s_ready symmetric. Neither ready depends on its own valid. At most one handshake per cycle.
- rr toggles to the other requester after every handshake that occurs while both are valid and eligible. Otherwise it is unchanged.
- Issue register: on handshake, t_valid←1. t_x0←x0. t_x1←x1 if pair, else 0. For S, operands are pre-scaled by arithmetic shift right 1 (sign preserved, LSB dropped). With no handshake, t_valid←0 and t_x holds its value.
- Tag pipe: LAT+1 stages of {valid, owner, pair}, loaded at issue and shifted every cycle. The head aligns with t_valid_out.
- Writeback on head.valid: push {y0, y1, pair} into owner's FIFO. For A, y = t_y. For S, y = (17-bit sign-extended t_y + 2048) >>> 1, truncated to 16 bits. Result range 0x0000..0x0800.
- Lane-1 result is written when pair=0 but is don't-care; ra/rs_y1 are forced to 0 when pair=0.
- err set when t_valid_out != head.valid. Cleared only by reset. The tag pipe remains authoritative for writes.
- FIFO: push and pop in the same cycle are allowed, including when full. The credit scheme guarantees push never meets full without a pop.

## Timing
- Reset values: a_ready=s_ready=0 while rst_n low. ra_valid=rs_valid=0, t_valid=0, t_x0=t_x1=0, err=0, cred=0, rr=A, tag pipe invalid, FIFOs empty.
- After reset release, readies follow the eligibility rule on the first cycle.
- Request handshake at edge N: t_valid high in cycle N+1. Result is written at edge N+1+LAT. r*_valid is high from cycle N+2+LAT when the FIFO was empty. Total latency is LAT+2.
- Throughput is one pair per cycle aggregate. A lone requester gets every cycle until its credits are exhausted.
- Response outputs come from FIFO registers. r*_valid stays high and data stays stable until the handshake.
- Reset asserted mid-operation: in-flight and buffered results are discarded. The tanh unit is reset by the same rst_n.

## Test plan
Bench uses an identity tanh stub (y=x, latency LAT=3).
- A only, x0=0x0800, x1=0xF800, pair=1, r*_ready=1 → ra_valid 5 cycles after handshake, y0=0x0800, y1=0xF800. rs_valid never rises.
- S only, x0=0x0800, x1=0x0000, pair=1 → rs_y0=0x0600, rs_y1=0x0400. Also x0=0xF000 → 0x0000 (prescale 0xF800).
- A and S valid every cycle, readies high → handshakes alternate A,S,A,S starting with A. Response order per requester is preserved.
- ra_ready=0, A valid continuously → exactly DEPTH=4 handshakes, then a_ready=0. Raising ra_ready for one pop yields a_ready=1 on the next cycle, and no result is lost.
- pair=0 with x1=0x7FFF → t_x1=0 and ra_y1=0. Stub drops one valid_out → err=1 and stays set.
- Assert rst_n low mid-stream → all outputs take reset values immediately. After release, no stale response appears.

Source files
------------

// File: rtl/act_lane_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | act_lane_scheduler: shares a 2-lane tanh unit between tanh and sigmoid   |
// | requesters with round-robin grant, tag pipe and credited output FIFOs.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module act_lane_scheduler #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_x0,
  input  logic [15:0] a_x1,
  input  logic        a_pair,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_x0,
  input  logic [15:0] s_x1,
  input  logic        s_pair,
  output logic        ra_valid,
  input  logic        ra_ready,
  output logic [15:0] ra_y0,
  output logic [15:0] ra_y1,
  output logic        ra_pair,
  output logic        rs_valid,
  input  logic        rs_ready,
  output logic [15:0] rs_y0,
  output logic [15:0] rs_y1,
  output logic        rs_pair,
  output logic        t_valid,
  output logic [15:0] t_x0,
  output logic [15:0] t_x1,
  input  logic        t_valid_out,
  input  logic [15:0] t_y0,
  input  logic [15:0] t_y1,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cred_a, cred_s;
  logic          elig_a, elig_s, rr;
  logic          a_hs, s_hs, ra_hs, rs_hs;

  assign elig_a  = cred_a < FULL;
  assign elig_s  = cred_s < FULL;
  assign a_ready = rst_n && elig_a && (!s_valid || !elig_s || !rr);
  assign s_ready = rst_n && elig_s && (!a_valid || !elig_a ||  rr);
  assign a_hs    = a_valid && a_ready;
  assign s_hs    = s_valid && s_ready;
  assign ra_hs   = ra_valid && ra_ready;
  assign rs_hs   = rs_valid && rs_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr     <= 1'b0;
      cred_a <= '0;
      cred_s <= '0;
    end else begin
      if (a_valid && s_valid && elig_a && elig_s) rr <= ~rr;
      case ({a_hs, ra_hs})
        2'b10:   cred_a <= cred_a + CW'(1);
        2'b01:   cred_a <= cred_a - CW'(1);
        default: ;
      endcase
      case ({s_hs, rs_hs})
        2'b10:   cred_s <= cred_s + CW'(1);
        2'b01:   cred_s <= cred_s - CW'(1);
        default: ;
      endcase
    end
  end

  // Sigmoid operands enter the unit halved, so tanh(x/2) comes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_valid <= 1'b0;
      t_x0    <= '0;
      t_x1    <= '0;
    end else begin
      t_valid <= a_hs || s_hs;
      if (a_hs) begin
        t_x0 <= a_x0;
        t_x1 <= a_pair ? a_x1 : 16'h0000;
      end else if (s_hs) begin
        t_x0 <= {s_x0[15], s_x0[15:1]};
        t_x1 <= s_pair ? {s_x1[15], s_x1[15:1]} : 16'h0000;
      end
    end
  end

  logic [LAT:0] tag_v, tag_s, tag_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_s <= '0;
      tag_p <= '0;
      err   <= 1'b0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], a_hs || s_hs};
      tag_s <= {tag_s[LAT-1:0], s_hs};
      tag_p <= {tag_p[LAT-1:0], a_hs ? a_pair : s_pair};
      if (t_valid_out != tag_v[LAT]) err <= 1'b1;
    end
  end

  logic [16:0] sum0, sum1;
  logic [15:0] wb_y0, wb_y1;
  logic [32:0] wdata;
  logic [1:0]  push, pop, nonempty;
  logic [1:0][32:0] fifo_q;

  assign sum0  = {t_y0[15], t_y0} + 17'd2048;
  assign sum1  = {t_y1[15], t_y1} + 17'd2048;
  assign wb_y0 = tag_s[LAT] ? sum0[16:1] : t_y0;
  assign wb_y1 = tag_s[LAT] ? sum1[16:1] : t_y1;
  assign wdata = {wb_y0, wb_y1, tag_p[LAT]};
  assign push  = {tag_v[LAT] && tag_s[LAT], tag_v[LAT] && !tag_s[LAT]};
  assign pop   = {rs_hs, ra_hs};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push[g]) wp <= wp + AW'(1);
        if (pop[g])  rp <= rp + AW'(1);
        if (push[g] && !pop[g])      cnt <= cnt + CW'(1);
        else if (!push[g] && pop[g]) cnt <= cnt - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem[wp] <= wdata;
    end

    assign nonempty[g] = cnt != '0;
    assign fifo_q[g]   = mem[rp];
  end

  assign ra_valid = nonempty[0];
  assign ra_y0    = fifo_q[0][32:17];
  assign ra_y1    = fifo_q[0][0] ? fifo_q[0][16:1] : 16'h0000;
  assign ra_pair  = fifo_q[0][0];
  assign rs_valid = nonempty[1];
  assign rs_y0    = fifo_q[1][32:17];
  assign rs_y1    = fifo_q[1][0] ? fifo_q[1][16:1] : 16'h0000;
  assign rs_pair  = fifo_q[1][0];

endmodule
`default_nettype wire

// File: tb/tb_act_lane_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_act_lane_scheduler: directed bench with an identity tanh stub.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_act_lane_scheduler;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_pair = 0, s_valid = 0, s_pair = 0;
  logic [15:0] a_x0 = 0, a_x1 = 0, s_x0 = 0, s_x1 = 0;
  logic        ra_ready = 0, rs_ready = 0, drop_arm = 0;
  logic        a_ready, s_ready, ra_valid, rs_valid, ra_pair, rs_pair;
  logic [15:0] ra_y0, ra_y1, rs_y0, rs_y1;
  logic        t_valid, t_valid_out, err;
  logic [15:0] t_x0, t_x1, t_y0, t_y1;

  act_lane_scheduler #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_x0(a_x0), .a_x1(a_x1), .a_pair(a_pair),
    .s_valid(s_valid), .s_ready(s_ready), .s_x0(s_x0), .s_x1(s_x1), .s_pair(s_pair),
    .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_y0(ra_y0), .ra_y1(ra_y1), .ra_pair(ra_pair),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_y0(rs_y0), .rs_y1(rs_y1), .rs_pair(rs_pair),
    .t_valid(t_valid), .t_x0(t_x0), .t_x1(t_x1),
    .t_valid_out(t_valid_out), .t_y0(t_y0), .t_y1(t_y1), .err(err)
  );

  // Identity tanh stub; drop_arm suppresses the valid of a sample entering it.
  logic [LAT-1:0]       sv;
  logic [LAT-1:0][15:0] sy0, sy1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv  <= '0;
      sy0 <= '0;
      sy1 <= '0;
    end else begin
      sv  <= {sv[LAT-2:0], t_valid & ~drop_arm};
      sy0 <= {sy0[LAT-2:0], t_x0};
      sy1 <= {sy1[LAT-2:0], t_x1};
    end
  end
  assign t_valid_out = sv[LAT-1];
  assign t_y0 = sy0[LAT-1];
  assign t_y1 = sy1[LAT-1];

  logic [15:0] ra_q0[$], ra_q1[$], rs_q0[$], rs_q1[$];
  always @(negedge clk) begin
    if (ra_valid && ra_ready) begin ra_q0.push_back(ra_y0); ra_q1.push_back(ra_y1); end
    if (rs_valid && rs_ready) begin rs_q0.push_back(rs_y0); rs_q1.push_back(rs_y1); end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_resp(input bit sig, output int n);
    n = 0;
    while (!(sig ? rs_valid : ra_valid) && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic clear_q();
    ra_q0.delete(); ra_q1.delete(); rs_q0.delete(); rs_q1.delete();
  endtask

  function automatic logic [15:0] q_at(input logic [15:0] q[$], input int k);
    return (k < q.size()) ? q[k] : 16'hDEAD;
  endfunction

  int n, hs;
  logic [15:0] exp_a[3] = '{16'h0100, 16'h0102, 16'h0104};
  logic [15:0] exp_s[3] = '{16'h0480, 16'h0481, 16'h0482};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_a_ready", a_ready, 0);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_ra_valid", ra_valid, 0);
    check_val("rst_t_valid", t_valid, 0);
    check_val("rst_t_x0", t_x0, 0);
    check_val("rst_err", err, 0);
    rst_n = 1'b1;
    #1;
    check_val("rel_a_ready", a_ready, 1);
    check_val("rel_s_ready", s_ready, 1);

    // tanh requester alone
    ra_ready = 1; rs_ready = 1;
    a_x0 = 16'h0800; a_x1 = 16'hF800; a_pair = 1; a_valid = 1;
    #1;
    check_val("a_ready", a_ready, 1);
    step();
    a_valid = 0;
    check_val("a_t_valid", t_valid, 1);
    check_val("a_t_x0", t_x0, 16'h0800);
    check_val("a_t_x1", t_x1, 16'hF800);
    wait_resp(0, n);
    check_val("a_latency", n, 4);
    check_val("a_y0", ra_y0, 16'h0800);
    check_val("a_y1", ra_y1, 16'hF800);
    check_val("a_pair", ra_pair, 1);
    step(); step();
    check_val("a_rs_quiet", rs_q0.size(), 0);
    check_val("a_ra_count", ra_q0.size(), 1);

    // sigmoid requester alone
    s_x0 = 16'h0800; s_x1 = 16'h0000; s_pair = 1; s_valid = 1;
    #1;
    step();
    s_valid = 0;
    check_val("s_t_x0", t_x0, 16'h0400);
    check_val("s_t_x1", t_x1, 16'h0000);
    wait_resp(1, n);
    check_val("s_latency", n, 4);
    check_val("s_y0", rs_y0, 16'h0600);
    check_val("s_y1", rs_y1, 16'h0400);
    step(); step();
    s_x0 = 16'hF000; s_x1 = 16'h1000; s_valid = 1;
    #1;
    step();
    s_valid = 0;
    check_val("s_neg_t_x0", t_x0, 16'hF800);
    check_val("s_max_t_x1", t_x1, 16'h0800);
    wait_resp(1, n);
    check_val("s_neg_y0", rs_y0, 16'h0000);
    check_val("s_max_y1", rs_y1, 16'h0800);
    step(); step();

    // both requesters streaming: strict alternation starting with A
    clear_q();
    for (int i = 0; i < 6; i++) begin
      a_x0 = 16'(16'h0100 + i); a_x1 = 0; a_pair = 1; a_valid = 1;
      s_x0 = 16'(16'h0200 + 2 * i); s_x1 = 0; s_pair = 1; s_valid = 1;
      #1;
      check_val($sformatf("alt_a_ready%0d", i), a_ready, (i % 2 == 0));
      check_val($sformatf("alt_s_ready%0d", i), s_ready, (i % 2 == 1));
      step();
    end
    a_valid = 0; s_valid = 0;
    repeat (10) step();
    check_val("alt_ra_count", ra_q0.size(), 3);
    check_val("alt_rs_count", rs_q0.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("alt_ra_y0_%0d", k), q_at(ra_q0, k), exp_a[k]);
      check_val($sformatf("alt_rs_y0_%0d", k), q_at(rs_q0, k), exp_s[k]);
    end

    // backpressure: credits cap acceptance at DEPTH
    clear_q();
    ra_ready = 0; hs = 0;
    for (int c = 0; c < 8; c++) begin
      a_x0 = 16'(16'h0300 + hs); a_x1 = 0; a_pair = 1; a_valid = 1;
      #1;
      if (a_ready) hs++;
      step();
    end
    check_val("bp_accepted", hs, DEPTH);
    #1;
    check_val("bp_full_ready", a_ready, 0);
    check_val("bp_head_y0", ra_y0, 16'h0300);
    ra_ready = 1;
    step();
    ra_ready = 0;
    #1;
    check_val("bp_credit_ready", a_ready, 1);
    step();
    a_valid = 0; ra_ready = 1;
    repeat (12) step();
    check_val("bp_count", ra_q0.size(), 5);
    for (int k = 0; k < 5; k++)
      check_val($sformatf("bp_y0_%0d", k), q_at(ra_q0, k), 16'(16'h0300 + k));

    // single-lane requests
    a_x0 = 16'h0123; a_x1 = 16'h7FFF; a_pair = 0; a_valid = 1;
    #1;
    step();
    a_valid = 0;
    check_val("p0_a_t_x1", t_x1, 16'h0000);
    wait_resp(0, n);
    check_val("p0_a_y0", ra_y0, 16'h0123);
    check_val("p0_a_y1", ra_y1, 16'h0000);
    check_val("p0_a_pair", ra_pair, 0);
    step(); step();
    s_x0 = 16'h0400; s_x1 = 16'h7FFF; s_pair = 0; s_valid = 1;
    #1;
    step();
    s_valid = 0;
    check_val("p0_s_t_x1", t_x1, 16'h0000);
    wait_resp(1, n);
    check_val("p0_s_y0", rs_y0, 16'h0500);
    check_val("p0_s_y1", rs_y1, 16'h0000);
    check_val("p0_s_pair", rs_pair, 0);
    step(); step();
    check_val("err_clean", err, 0);

    // stub loses one valid_out
    clear_q();
    drop_arm = 1;
    a_x0 = 16'h0055; a_x1 = 16'h0066; a_pair = 1; a_valid = 1;
    #1;
    step();
    a_valid = 0;
    step();
    drop_arm = 0;
    repeat (4) step();
    check_val("err_set", err, 1);
    repeat (5) step();
    check_val("err_sticky", err, 1);
    check_val("drop_count", ra_q0.size(), 1);
    check_val("drop_y0", q_at(ra_q0, 0), 16'h0055);

    // reset in the middle of traffic
    ra_ready = 0; rs_ready = 0;
    a_x0 = 16'h0011; a_pair = 1; a_valid = 1;
    s_x0 = 16'h0022; s_pair = 1; s_valid = 1;
    repeat (6) step();
    check_val("pre_rst_ra_valid", ra_valid, 1);
    rst_n = 0;
    #1;
    check_val("mid_rst_a_ready", a_ready, 0);
    check_val("mid_rst_s_ready", s_ready, 0);
    check_val("mid_rst_ra_valid", ra_valid, 0);
    check_val("mid_rst_rs_valid", rs_valid, 0);
    check_val("mid_rst_t_valid", t_valid, 0);
    check_val("mid_rst_t_x0", t_x0, 0);
    check_val("mid_rst_t_x1", t_x1, 0);
    check_val("mid_rst_err", err, 0);
    a_valid = 0; s_valid = 0;
    step(); step();
    rst_n = 1; ra_ready = 1; rs_ready = 1;
    clear_q();
    repeat (12) step();
    check_val("post_rst_ra_stale", ra_q0.size(), 0);
    check_val("post_rst_rs_stale", rs_q0.size(), 0);
    check_val("post_rst_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
